// File: rtl/ps_irq_pkg.sv
// ps_irq_pkg: shared ureg addresses, FSM encoding and bit-scan helpers for the
// program-sequencer interrupt controller.
package ps_irq_pkg;
    localparam int VEC_W = 16;
    localparam logic [1:0] IC_IMASK  = 2'd0;
    localparam logic [1:0] IC_IRPTL  = 2'd1;
    localparam logic [1:0] IC_IMASKP = 2'd2;
    localparam logic [1:0] IC_GIE    = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;

    // Index of the lowest set bit; 16 when no bit is set.
    function automatic logic [4:0] lsb_idx(input logic [15:0] v);
        logic [4:0] r;
        r = 5'd16;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 5'(i);
        return r;
    endfunction

    function automatic logic [4:0] pop_cnt(input logic [15:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 16; i++) r = r + 5'(v[i]);
        return r;
    endfunction
endpackage

// File: rtl/ps_irq_sync.sv
// ps_irq_sync: two-flop synchroniser for one async IRQ line plus a one-cycle
// rising-edge pulse taken from the synchronised level.
module ps_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic rise
);
    logic s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/ps_irq_ctrl.sv
// ps_irq_ctrl: IRQ latch/mask, priority pick and req/ack vector handshake for the
// sequencer. Define PS_IRQ_NEST_EN to allow nested service up to NEST_MAX levels.
module ps_irq_ctrl
    import ps_irq_pkg::*;
#(
    parameter int          NIRQ       = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter int          VEC_STRIDE = 4,
    parameter int          NEST_MAX   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            ps_ic_wrt_en,
    input  logic [1:0]      ps_ic_wrt_add,
    input  logic [15:0]     ps_ic_wdt,
    input  logic [1:0]      ps_ic_rd_add,
    output logic [15:0]     ic_ps_rdt,
    output logic            ic_ps_req,
    output logic [15:0]     ic_ps_vec,
    input  logic            ps_ic_ack,
    input  logic            ps_ic_rti
);
    localparam int IW = $clog2(NIRQ);

    logic [NIRQ-1:0]  rise, elig, ack_oh, rti_cand, rti_oh, wdt_n;
    logic [NIRQ-1:0]  imask_q, imask_d, irptl_q, irptl_d, imaskp_q, imaskp_d;
    logic             gie_q, gie_d, win_vld, allow, start, ack_fire;
    logic [4:0]       win_pos;
    logic [IW-1:0]    sel_q, sel_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    state_e           state_q, state_d;
    logic             unused_ok;

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        ps_irq_sync u_sync (.clk(clk), .rst(rst), .irq_in(irq_in[g]), .rise(rise[g]));
    end

`ifdef PS_IRQ_NEST_EN
    logic [4:0] mp_low, mp_cnt;
    always_comb begin
        mp_low = lsb_idx(VEC_W'(imaskp_q));
        mp_cnt = pop_cnt(VEC_W'(imaskp_q));
        allow  = (int'(mp_cnt) < NEST_MAX) && (win_pos < mp_low);
    end
`else
    assign allow = ~|imaskp_q;
`endif

    always_comb begin
        wdt_n    = ps_ic_wdt[NIRQ-1:0];
        elig     = irptl_q & imask_q & {NIRQ{gie_q}};
        win_pos  = lsb_idx(VEC_W'(elig));
        win_vld  = |elig;
        start    = win_vld && allow && (state_q != REQ);
        ack_fire = ps_ic_ack && (state_q == REQ);
        ack_oh   = ack_fire ? NIRQ'(1) << sel_q : '0;
        // RTI retires the highest-priority in-service bit other than one being acked now
        rti_cand = imaskp_q & ~ack_oh;
        rti_oh   = ps_ic_rti ? rti_cand & (~rti_cand + NIRQ'(1)) : '0;
        imask_d  = (ps_ic_wrt_en && ps_ic_wrt_add == IC_IMASK) ? wdt_n : imask_q;
        gie_d    = (ps_ic_wrt_en && ps_ic_wrt_add == IC_GIE) ? ps_ic_wdt[0] : gie_q;
        irptl_d  = (((ps_ic_wrt_en && ps_ic_wrt_add == IC_IRPTL) ? wdt_n : irptl_q) & ~ack_oh) | rise;
        imaskp_d = (((ps_ic_wrt_en && ps_ic_wrt_add == IC_IMASKP) ? wdt_n : imaskp_q) | ack_oh) & ~rti_oh;
        sel_d    = start ? win_pos[IW-1:0] : sel_q;
        vec_d    = start ? VEC_BASE + VEC_W'(win_pos) * VEC_W'(VEC_STRIDE) : vec_q;
        state_d  = (state_q == REQ) ? (ack_fire ? SERVICE : REQ) :
                   start ? REQ : (|imaskp_d ? SERVICE : IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imask_q  <= '0;
            irptl_q  <= '0;
            imaskp_q <= '0;
            gie_q    <= 1'b0;
            sel_q    <= '0;
            vec_q    <= '0;
            state_q  <= IDLE;
        end else begin
            imask_q  <= imask_d;
            irptl_q  <= irptl_d;
            imaskp_q <= imaskp_d;
            gie_q    <= gie_d;
            sel_q    <= sel_d;
            vec_q    <= vec_d;
            state_q  <= state_d;
        end
    end

    assign ic_ps_req = (state_q == REQ);
    assign ic_ps_vec = vec_q;
    assign ic_ps_rdt = (ps_ic_rd_add == IC_IMASK)  ? VEC_W'(imask_q)  :
                       (ps_ic_rd_add == IC_IRPTL)  ? VEC_W'(irptl_q)  :
                       (ps_ic_rd_add == IC_IMASKP) ? VEC_W'(imaskp_q) : VEC_W'(gie_q);
    assign unused_ok = ^{ps_ic_wdt, NEST_MAX[0]};
endmodule

// File: tb/tb_ps_irq_ctrl.sv
// tb_ps_irq_ctrl: directed handshake scenarios with literal expectations, then random
// traffic, all checked every cycle against a rule-level model of the controller.
module tb_ps_irq_ctrl;
    localparam int NIRQ = 4;
    localparam int NEST_MAX = 2;

    logic        clk, rst;
    logic [3:0]  irq_in;
    logic        ps_ic_wrt_en, ps_ic_ack, ps_ic_rti, ic_ps_req;
    logic [1:0]  ps_ic_wrt_add, ps_ic_rd_add;
    logic [15:0] ps_ic_wdt, ic_ps_rdt, ic_ps_vec;
    int errors = 0, checks = 0;

    ps_irq_ctrl #(.NIRQ(NIRQ), .VEC_BASE(16'h0010), .VEC_STRIDE(4), .NEST_MAX(NEST_MAX)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ps_ic_wrt_en(ps_ic_wrt_en),
        .ps_ic_wrt_add(ps_ic_wrt_add), .ps_ic_wdt(ps_ic_wdt), .ps_ic_rd_add(ps_ic_rd_add),
        .ic_ps_rdt(ic_ps_rdt), .ic_ps_req(ic_ps_req), .ic_ps_vec(ic_ps_vec),
        .ps_ic_ack(ps_ic_ack), .ps_ic_rti(ps_ic_rti));

    initial clk = 0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  imask, irptl, imaskp;
        logic        gie, req;
        int          sel;
        logic [15:0] vec;
        logic [3:0]  h0, h1, h2;
    } mstate_t;

    mstate_t m = '{default: 0};

    // One clock of the controller's rules applied to the model state.
    function automatic mstate_t step(input mstate_t s);
        mstate_t n = s;
        logic [3:0] rs, el;
        int w = -1;
        bit ok, ack, done;
        rs = s.h1 & ~s.h2;
        n.h2 = s.h1; n.h1 = s.h0; n.h0 = irq_in;
        el = s.irptl & s.imask & {4{s.gie}};
        for (int i = 0; i < NIRQ; i++) if (el[i] && w < 0) w = i;
`ifdef PS_IRQ_NEST_EN
        begin
            int low = NIRQ;
            for (int i = 0; i < NIRQ; i++) if (s.imaskp[i] && low == NIRQ) low = i;
            ok = (w >= 0) && (w < low) && ($countones(s.imaskp) < NEST_MAX);
        end
`else
        ok = (w >= 0) && (s.imaskp == 0);
`endif
        ack = ps_ic_ack && s.req;
        if (ps_ic_wrt_en) begin
            if (ps_ic_wrt_add == 0) n.imask = ps_ic_wdt[3:0];
            if (ps_ic_wrt_add == 1) n.irptl = ps_ic_wdt[3:0];
            if (ps_ic_wrt_add == 2) n.imaskp = ps_ic_wdt[3:0];
            if (ps_ic_wrt_add == 3) n.gie = ps_ic_wdt[0];
        end
        if (ack) begin n.irptl[s.sel] = 1'b0; n.imaskp[s.sel] = 1'b1; end
        n.irptl = n.irptl | rs;
        done = 0;
        if (ps_ic_rti)
            for (int i = 0; i < NIRQ; i++)
                if (!done && s.imaskp[i] && !(ack && i == s.sel)) begin n.imaskp[i] = 1'b0; done = 1; end
        if (s.req) n.req = !ack;
        else if (ok) begin n.req = 1'b1; n.sel = w; n.vec = 16'h0010 + 16'(4 * w); end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{default: 0};
        else m <= step(m);
    end

    always @(negedge clk) begin
        logic [15:0] exp_rdt;
        exp_rdt = (ps_ic_rd_add == 0) ? {12'b0, m.imask} : (ps_ic_rd_add == 1) ? {12'b0, m.irptl} :
                  (ps_ic_rd_add == 2) ? {12'b0, m.imaskp} : {15'b0, m.gie};
        checks++;
        if (ic_ps_req !== m.req) begin
            errors++;
            $display("FAIL model_req t=%0t: got %b expected %b", $time, ic_ps_req, m.req);
        end
        if (m.req) begin
            checks++;
            if (ic_ps_vec !== m.vec) begin
                errors++;
                $display("FAIL model_vec t=%0t: got %h expected %h", $time, ic_ps_vec, m.vec);
            end
        end
        checks++;
        if (ic_ps_rdt !== exp_rdt) begin
            errors++;
            $display("FAIL model_rdt[%0d] t=%0t: got %h expected %h", ps_ic_rd_add, $time, ic_ps_rdt, exp_rdt);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [15:0] exp);
        ps_ic_rd_add = a;
        #1;
        chk(name, ic_ps_rdt, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        ps_ic_wrt_en = 1; ps_ic_wrt_add = a; ps_ic_wdt = d;
        cyc();
        ps_ic_wrt_en = 0;
    endtask

    task automatic do_ack();
        ps_ic_ack = 1; cyc(); ps_ic_ack = 0;
    endtask

    task automatic do_rti();
        ps_ic_rti = 1; cyc(); ps_ic_rti = 0;
    endtask

    initial begin
        rst = 0; irq_in = 0; ps_ic_wrt_en = 0; ps_ic_wrt_add = 0; ps_ic_wdt = 0;
        ps_ic_rd_add = 0; ps_ic_ack = 0; ps_ic_rti = 0;
        repeat (2) cyc();
        chk("rst_req", 16'(ic_ps_req), 16'h0);
        chk("rst_vec", ic_ps_vec, 16'h0);
        for (int a = 0; a < 4; a++) rdchk("rst_reg", 2'(a), 16'h0);
        rst = 1; cyc();
        wr(3, 16'h1); wr(0, 16'hF);

        // single interrupt on line 2
        irq_in = 4'b0100; cyc(); cyc();
        rdchk("s1_irptl_early", 1, 16'h0);
        cyc();
        rdchk("s1_irptl", 1, 16'h4);
        chk("s1_req_early", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s1_req", 16'(ic_ps_req), 16'h1);
        chk("s1_vec", ic_ps_vec, 16'h0018);
        do_ack();
        chk("s1_req_ack", 16'(ic_ps_req), 16'h0);
        rdchk("s1_irptl_ack", 1, 16'h0);
        rdchk("s1_imaskp", 2, 16'h4);
        irq_in = 0;
        do_rti();
        rdchk("s1_imaskp_rti", 2, 16'h0);
        cyc();

        // simultaneous lines 1 and 3
        irq_in = 4'b1010; repeat (4) cyc();
        chk("s2_req", 16'(ic_ps_req), 16'h1);
        chk("s2_vec", ic_ps_vec, 16'h0014);
        do_ack();
        rdchk("s2_irptl", 1, 16'h8);
        rdchk("s2_imaskp", 2, 16'h2);
        do_rti();
        chk("s2_req_gap", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s2_req2", 16'(ic_ps_req), 16'h1);
        chk("s2_vec2", ic_ps_vec, 16'h001C);
        do_ack(); do_rti();
        irq_in = 0; cyc();

        // masked pending, then unmask
        wr(0, 16'h0);
        irq_in = 4'b0001; repeat (5) cyc();
        rdchk("s3_irptl", 1, 16'h1);
        chk("s3_req_masked", 16'(ic_ps_req), 16'h0);
        wr(0, 16'h1);
        chk("s3_req_lat", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s3_req", 16'(ic_ps_req), 16'h1);
        chk("s3_vec", ic_ps_vec, 16'h0010);
        do_ack(); do_rti();
        irq_in = 0; wr(0, 16'hF);

        // edge set colliding with ack clear on the same line
        irq_in = 4'b0010; repeat (4) cyc();
        chk("s4_vec", ic_ps_vec, 16'h0014);
        irq_in = 0; cyc(); cyc();
        irq_in = 4'b0010; cyc(); cyc();
        do_ack();
        rdchk("s4_irptl", 1, 16'h2);
        rdchk("s4_imaskp", 2, 16'h2);
        chk("s4_req_ack", 16'(ic_ps_req), 16'h0);
        do_rti(); cyc();
        chk("s4_req_repend", 16'(ic_ps_req), 16'h1);
        chk("s4_vec_repend", ic_ps_vec, 16'h0014);
        do_ack(); do_rti();
        irq_in = 0; cyc(); cyc();

        // higher-priority arrival during service
        irq_in = 4'b0100; repeat (4) cyc();
        chk("s5_vec", ic_ps_vec, 16'h0018);
        do_ack();
        irq_in = 4'b0101; repeat (4) cyc();
`ifdef PS_IRQ_NEST_EN
        chk("s5_nest_req", 16'(ic_ps_req), 16'h1);
        chk("s5_nest_vec", ic_ps_vec, 16'h0010);
        do_ack();
        rdchk("s5_imaskp", 2, 16'h5);
        irq_in = 4'b1101; repeat (6) cyc();
        chk("s5_low_blocked", 16'(ic_ps_req), 16'h0);
        do_rti();
        rdchk("s5_imaskp_rti", 2, 16'h4);
        do_rti();
        chk("s5_req_gap", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s5_req3", 16'(ic_ps_req), 16'h1);
        chk("s5_vec3", ic_ps_vec, 16'h001C);
        do_ack(); do_rti();
        irq_in = 0; cyc(); cyc();
        irq_in = 4'b1000; repeat (4) cyc();
        do_ack();
        irq_in = 4'b1100; repeat (4) cyc();
        chk("s5_depth2_vec", ic_ps_vec, 16'h0018);
        do_ack();
        irq_in = 4'b1110; repeat (6) cyc();
        chk("s5_depth_blocked", 16'(ic_ps_req), 16'h0);
        do_rti();
        chk("s5_depth_gap", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s5_depth_req", 16'(ic_ps_req), 16'h1);
        chk("s5_depth_vec", ic_ps_vec, 16'h0014);
        do_ack(); do_rti(); do_rti();
`else
        chk("s5_single_blocked", 16'(ic_ps_req), 16'h0);
        do_rti();
        chk("s5_req_gap", 16'(ic_ps_req), 16'h0);
        cyc();
        chk("s5_req", 16'(ic_ps_req), 16'h1);
        chk("s5_vec0", ic_ps_vec, 16'h0010);
        do_ack(); do_rti();
`endif
        irq_in = 0; cyc(); cyc();

        // reset in the middle of a handshake
        irq_in = 4'b0001; repeat (4) cyc();
        chk("s6_req", 16'(ic_ps_req), 16'h1);
        rst = 0; #1;
        chk("s6_req_rst", 16'(ic_ps_req), 16'h0);
        chk("s6_vec_rst", ic_ps_vec, 16'h0);
        for (int a = 0; a < 4; a++) rdchk("s6_reg_rst", 2'(a), 16'h0);
        irq_in = 0; cyc();
        rst = 1; ps_ic_ack = 1; cyc(); ps_ic_ack = 0;
        chk("s6_ack_ignored", 16'(ic_ps_req), 16'h0);
        rdchk("s6_imaskp", 2, 16'h0);

        // random traffic
        wr(3, 16'h1); wr(0, 16'hF);
        for (int n = 0; n < 3000; n++) begin
            int a;
            irq_in = irq_in ^ (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
            a = $urandom_range(0, 2);
            ps_ic_wrt_en = ($urandom_range(0, 9) == 0);
            ps_ic_wrt_add = (a == 2) ? 2'd3 : 2'(a);
            ps_ic_wdt = 16'($urandom);
            if (a == 2) ps_ic_wdt[0] = ($urandom_range(0, 3) != 0);
            ps_ic_ack = 1'($urandom_range(0, 1));
            ps_ic_rti = ($urandom_range(0, 5) == 0);
            ps_ic_rd_add = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst = 1; ps_ic_wrt_en = 0; ps_ic_ack = 0; ps_ic_rti = 0;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
